// File: rtl/rv_bus_arb.sv
// rv_bus_arb: arbiter for the shared memory bus between instruction fetch and
// load/store. Data has priority; a saturating starvation counter forces a fetch
// grant after STARVE_MAX consecutive data grants while fetch waits. One
// transaction is outstanding at a time. Bus outputs are registered at grant.
// Optional build macro RV_BUS_ARB_TIMEOUT_EN adds o_bus_err and a watchdog
// that aborts a grant after TIMEOUT_CYC cycles without i_bus_ack.
module rv_bus_arb #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_fetch_req,
    input  logic [ADDR_W-1:0]   i_fetch_addr,
    output logic                o_fetch_ack,
    output logic [DATA_W-1:0]   o_fetch_rdata,
    input  logic                i_data_req,
    input  logic                i_data_we,
    input  logic [DATA_W/8-1:0] i_data_sel,
    input  logic [ADDR_W-1:0]   i_data_addr,
    input  logic [DATA_W-1:0]   i_data_wdata,
    output logic                o_data_ack,
    output logic [DATA_W-1:0]   o_data_rdata,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [DATA_W/8-1:0] o_bus_sel,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_wdata,
    input  logic                i_bus_ack,
    input  logic [DATA_W-1:0]   i_bus_rdata,
    output logic                o_busy
`ifdef RV_BUS_ARB_TIMEOUT_EN
    ,
    output logic                o_bus_err
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT_CYC);

    // Reject parameter values the counters cannot represent.
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("rv_bus_arb: STARVE_MAX must be 1..15 and TIMEOUT_CYC 1..255");
    end

    state_t     state, next_state;
    logic [3:0] starve_cnt;
    logic       launch_fetch, launch_data, done;
    logic       timeout;

`ifdef RV_BUS_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // A real ack in the same cycle always beats the watchdog.
    assign timeout   = (state != IDLE) && !i_bus_ack && (tmo_cnt == TMO_LIM);
    assign o_bus_err = timeout;

    // Watchdog: cleared on every launch, counts stalled grant cycles.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt <= '0;
        end else if (launch_fetch || launch_data) begin
            tmo_cnt <= '0;
        end else if (state != IDLE && !i_bus_ack && tmo_cnt != TMO_LIM) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Arbitration and grant completion; launch/done strobes feed the registers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        next_state   = state;
        launch_fetch = 1'b0;
        launch_data  = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (i_data_req && !(i_fetch_req && starve_cnt == STARVE_LIM)) begin
                    next_state  = GNT_DATA;
                    launch_data = 1'b1;
                end else if (i_fetch_req) begin
                    next_state   = GNT_FETCH;
                    launch_fetch = 1'b1;
                end
            end
            GNT_FETCH, GNT_DATA: begin
                if (i_bus_ack || timeout) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; async reset abandons any grant in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (!i_reset_n) state <= IDLE;
        else            state <= next_state;
    end

    // Starvation counter: counts data grants that jumped a waiting fetch.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_cnt <= '0;
        end else if (launch_fetch) begin
            starve_cnt <= '0;
        end else if (launch_data && i_fetch_req && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Bus outputs: captured from the winner on the grant edge, held until done.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_sel   <= '0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
        end else if (launch_data) begin
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_data_we;
            o_bus_sel   <= i_data_sel;
            o_bus_addr  <= i_data_addr;
            o_bus_wdata <= i_data_wdata;
        end else if (launch_fetch) begin
            o_bus_req   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_sel   <= '1;
            o_bus_addr  <= i_fetch_addr;
            o_bus_wdata <= '0;
        end else if (done) begin
            o_bus_req   <= 1'b0;
        end
    end

    assign o_fetch_ack   = (state == GNT_FETCH) && (i_bus_ack || timeout);
    assign o_data_ack    = (state == GNT_DATA)  && (i_bus_ack || timeout);
    assign o_fetch_rdata = i_bus_rdata;
    assign o_data_rdata  = i_bus_rdata;
    assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_rv_bus_arb.sv
// tb_rv_bus_arb: directed scenarios plus randomized requesters/bus responder,
// checked every cycle against a transaction-level model of the arbiter.
module tb_rv_bus_arb;

    localparam int STARVE_MAX = 4;
`ifdef RV_BUS_ARB_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 8;
`else
    localparam int TIMEOUT_CYC = 255;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_fetch_req = 1'b0;
    logic [31:0] i_fetch_addr = '0;
    logic        o_fetch_ack;
    logic [31:0] o_fetch_rdata;
    logic        i_data_req = 1'b0;
    logic        i_data_we = 1'b0;
    logic [3:0]  i_data_sel = '0;
    logic [31:0] i_data_addr = '0;
    logic [31:0] i_data_wdata = '0;
    logic        o_data_ack;
    logic [31:0] o_data_rdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        o_busy;
`ifdef RV_BUS_ARB_TIMEOUT_EN
    logic        o_bus_err;
`endif

    rv_bus_arb #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
        .o_fetch_ack(o_fetch_ack), .o_fetch_rdata(o_fetch_rdata),
        .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_sel(i_data_sel),
        .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
        .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_sel(o_bus_sel),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
        .o_busy(o_busy)
`ifdef RV_BUS_ARB_TIMEOUT_EN
        , .o_bus_err(o_bus_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Transaction-level model: who owns the bus, what was launched, and how
    // many data grants in a row have overtaken a waiting fetch.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_starve;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_owner <= 0; m_starve <= 0;
            m_we <= 1'b0; m_sel <= '0; m_addr <= '0; m_wdata <= '0;
        end else if (m_owner == 0) begin
            if (i_data_req && !(i_fetch_req && m_starve == STARVE_MAX)) begin
                m_owner <= 2;
                m_we <= i_data_we; m_sel <= i_data_sel;
                m_addr <= i_data_addr; m_wdata <= i_data_wdata;
                if (i_fetch_req) m_starve <= (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            end else if (i_fetch_req) begin
                m_owner <= 1;
                m_we <= 1'b0; m_sel <= 4'hF; m_addr <= i_fetch_addr; m_wdata <= '0;
                m_starve <= 0;
            end
        end else if (i_bus_ack) begin
            m_owner <= 0;
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge i_clk) begin
        if (i_reset_n && chk_en) begin
            check("bus_req", o_bus_req, m_owner != 0);
            check("busy", o_busy, m_owner != 0);
            if (m_owner != 0)
                check("bus_fields", {o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata},
                      {m_we, m_sel, m_addr, m_wdata});
            check("fetch_ack", o_fetch_ack, i_bus_ack && m_owner == 1);
            check("data_ack", o_data_ack, i_bus_ack && m_owner == 2);
            check("rdata", {o_fetch_rdata, o_data_rdata}, {i_bus_rdata, i_bus_rdata});
`ifdef RV_BUS_ARB_TIMEOUT_EN
            check("bus_err", o_bus_err, 1'b0);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_owner;
        int stall;
        bit done_f, done_d, heavy;

        // Reset state
        #2;
        check("rst_bus", {o_bus_req, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata}, '0);
        check("rst_busy", o_busy, 1'b0);
        tick();
        i_reset_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Fetch only, bus acks two cycles after o_bus_req
        i_fetch_req = 1'b1; i_fetch_addr = 32'h100;
        tick();
        #1 check("fo_launch", {o_bus_req, o_bus_we, o_bus_sel, o_bus_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
        tick();
        tick();
        i_bus_ack = 1'b1; i_bus_rdata = 32'h0000_0013;
        #1 check("fo_ack", {o_fetch_ack, o_fetch_rdata, o_data_ack}, {1'b1, 32'h13, 1'b0});
        tick();
        i_bus_ack = 1'b0; i_fetch_req = 1'b0;
        #1 check("fo_done", {o_fetch_ack, o_bus_req}, 2'b00);
        tick();

        // Simultaneous requests: data first, fetch after one idle cycle
        i_fetch_req = 1'b1; i_fetch_addr = 32'h200;
        i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h8000;
        i_data_wdata = 32'hDEAD_BEEF; i_data_sel = 4'h3;
        tick();
        i_bus_ack = 1'b1;
        #1 check("sim_data", {o_bus_req, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata},
                 {1'b1, 1'b1, 4'h3, 32'h8000, 32'hDEAD_BEEF});
        check("sim_data_ack", {o_data_ack, o_fetch_ack}, 2'b10);
        tick();
        i_bus_ack = 1'b0; i_data_req = 1'b0;
        #1 check("sim_idle", {o_bus_req, o_busy}, 2'b00);
        tick();
        i_bus_ack = 1'b1;
        #1 check("sim_fetch", {o_bus_req, o_bus_we, o_bus_addr, o_fetch_ack}, {1'b1, 1'b0, 32'h200, 1'b1});
        tick();
        i_bus_ack = 1'b0; i_fetch_req = 1'b0;
        tick();

        // Starvation: exactly STARVE_MAX data grants, then fetch
        i_fetch_req = 1'b1; i_fetch_addr = 32'h300;
        i_data_req = 1'b1; i_data_we = 1'b1; i_data_sel = 4'hF;
        i_data_addr = 32'h9000; i_data_wdata = 32'h1;
        for (int k = 0; k < STARVE_MAX; k++) begin
            tick();
            #1 check("starve_data_grant", {o_bus_req, o_bus_we, o_bus_addr},
                     {1'b1, 1'b1, 32'h9000 + 32'(k * 4)});
            i_bus_ack = 1'b1;
            tick();
            i_bus_ack = 1'b0;
            i_data_addr = 32'h9000 + 32'((k + 1) * 4);
        end
        tick();
        #1 check("starve_fetch_grant", {o_bus_req, o_bus_we, o_bus_addr}, {1'b1, 1'b0, 32'h300});
        check("starve_model_reset", m_starve, 0);
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0; i_fetch_req = 1'b0; i_data_req = 1'b0;
        tick();

        // Async reset during GNT_DATA with a pending ack
        i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'hA000;
        tick();
        #1 check("rst_mid_grant", o_bus_req, 1'b1);
        i_bus_ack = 1'b1;
        i_reset_n = 1'b0;
        #1 check("rst_mid_drop", {o_bus_req, o_busy, o_data_ack}, 3'b000);
        tick();
        i_bus_ack = 1'b0; i_data_req = 1'b0;
        tick();
        i_reset_n = 1'b1;
        tick();
        i_fetch_req = 1'b1; i_fetch_addr = 32'h400;
        tick();
        i_bus_ack = 1'b1;
        #1 check("rst_after_fetch", {o_bus_req, o_bus_addr, o_fetch_ack}, {1'b1, 32'h400, 1'b1});
        tick();
        i_bus_ack = 1'b0; i_fetch_req = 1'b0;
        tick();

        // Stray ack in IDLE
        i_bus_ack = 1'b1;
        #1 check("stray_ack", {o_fetch_ack, o_data_ack}, 2'b00);
        tick();
        i_bus_ack = 1'b0;
        #1 check("stray_state", {o_busy, o_bus_req}, 2'b00);
        tick();

`ifdef RV_BUS_ARB_TIMEOUT_EN
        // Bus never acks a load: watchdog aborts with o_bus_err
        begin
            int  n;
            bit  got;
            chk_en = 1'b0;
            i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'hB000; i_data_sel = 4'hF;
            n = 0; got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                tick();
                n++;
                #1;
                if (o_data_ack) begin
                    got = 1'b1;
                    check("tmo_err", o_bus_err, 1'b1);
                end
            end
            check("tmo_seen", got, 1'b1);
            check("tmo_cycles", (n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 1), 1'b1);
            tick();
            i_data_req = 1'b0;
            #1 check("tmo_after", {o_bus_req, o_busy, o_data_ack, o_bus_err}, 4'b0000);
            i_reset_n = 1'b0;
            tick();
            i_reset_n = 1'b1;
            chk_en = 1'b1;
            tick();
        end
`endif

        // Randomized traffic checked cycle by cycle against the model
        last_owner = 0; stall = 0; heavy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i % 500 == 0) heavy = ~heavy;
            done_f = i_bus_ack && last_owner == 1;
            done_d = i_bus_ack && last_owner == 2;
            if (!i_fetch_req || done_f) begin
                i_fetch_req  = heavy ? 1'b1 : ($urandom_range(0, 9) < 6);
                i_fetch_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!i_data_req || done_d) begin
                i_data_req   = heavy ? 1'b1 : ($urandom_range(0, 9) < 5);
                i_data_we    = 1'($urandom_range(0, 1));
                i_data_sel   = 4'($urandom_range(0, 15));
                i_data_addr  = $urandom;
                i_data_wdata = $urandom;
            end
            if (m_owner != 0) begin
                i_bus_ack = (stall >= 3) || ($urandom_range(0, 2) == 0);
                stall     = i_bus_ack ? 0 : stall + 1;
            end else begin
                stall     = 0;
                i_bus_ack = ($urandom_range(0, 7) == 0);
            end
            i_bus_rdata = $urandom;
            last_owner  = m_owner;
        end
        tick();
        i_fetch_req = 1'b0; i_data_req = 1'b0; i_bus_ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
